// File: rtl/bitscan_encoder_seq.sv
`timescale 1ns/1ps
// Sequential bit-scan encoder: latches a request vector and emits the index of
// each set bit, one per output handshake, in the configured priority order.
module bitscan_encoder_seq #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_onehot,
    output logic [IDX_W:0]   vec_count,
    output logic             zero_seen
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W:0]   vec_count_q, vec_count_d;
    logic             onehot_q, onehot_d;
    logic             zero_seen_q, zero_seen_d;
    logic             alive_q;

    logic [IDX_W-1:0] scan_idx;
    logic             single_bit;
    logic [IDX_W:0]   in_pop;

    // Priority decode of the pending mask; only indices below WIDTH can be produced.
    always_comb begin
        scan_idx = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (pending_q[i]) scan_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pending_q[i]) scan_idx = IDX_W'(i);
            end
        end
    end

    assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

    always_comb begin
        in_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_pop = in_pop + (IDX_W+1)'(in_vec[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        vec_count_d = vec_count_q;
        onehot_d    = onehot_q;
        zero_seen_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_vec != '0) begin
                        pending_d   = in_vec;
                        vec_count_d = in_pop;
                        onehot_d    = (in_pop == (IDX_W+1)'(1));
                        state_d     = SCAN;
                    end else begin
                        zero_seen_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(ONE << scan_idx);
                    if (single_bit) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            vec_count_q <= '0;
            onehot_q    <= 1'b0;
            zero_seen_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            vec_count_q <= vec_count_d;
            onehot_q    <= onehot_d;
            zero_seen_q <= zero_seen_d;
            alive_q     <= 1'b1;
        end
    end

    // alive_q keeps in_ready low until the first edge after reset release.
    assign in_ready   = alive_q && (state_q == IDLE);
    assign out_valid  = (state_q == SCAN);
    assign out_idx    = scan_idx;
    assign out_last   = single_bit;
    assign out_onehot = onehot_q;
    assign vec_count  = vec_count_q;
    assign zero_seen  = zero_seen_q;

endmodule
